// File: rtl/calc_pkg.sv
// ----------------------------------------------------------------------------
// calc_pkg
// Definitions shared by the keypad scanner and the calculator core, so both
// agree on the command encoding.
//   scan_state_t : keypad scanner FSM states
//   CMD_*        : operator command codes (digits encode as their value)
//   KEY_MAP      : 16-entry key-to-command table, indexed by {row, col}
//   key_code()   : KEY_MAP lookup from a row/column pair
//   lowest_low() : index of the lowest-numbered active-low row
// ----------------------------------------------------------------------------
package calc_pkg;

    typedef enum logic [2:0] {
        SCAN,
        DEBOUNCE,
        EMIT,
        HELD,
        RELEASE
    } scan_state_t;

    localparam logic [3:0] CMD_ADD = 4'b1010;
    localparam logic [3:0] CMD_SUB = 4'b1011;
    localparam logic [3:0] CMD_MUL = 4'b1100;
    localparam logic [3:0] CMD_D   = 4'b1101;
    localparam logic [3:0] CMD_EQ  = 4'b1110;
    localparam logic [3:0] CMD_CLR = 4'b1111;

    // Physical layout, row 0 at the top, column 0 on the left:
    //   1 2 3 A
    //   4 5 6 B
    //   7 8 9 C
    //   * 0 # D
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1,    4'h2, 4'h3,   CMD_ADD,
        4'h4,    4'h5, 4'h6,   CMD_SUB,
        4'h7,    4'h8, 4'h9,   CMD_MUL,
        CMD_CLR, 4'h0, CMD_EQ, CMD_D
    };

    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        return KEY_MAP[{row, col}];
    endfunction

    // Scanning from the top index down lets the lowest low row win.
    function automatic logic [1:0] lowest_low(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// ----------------------------------------------------------------------------
// keypad_scan_if
// Command bus from the keypad scanner to the calculator core.
//   cmd       : command code, holds its value between strobes
//   cmd_valid : one-cycle strobe marking a new cmd
//   key_held  : high while an accepted key remains pressed
// Modports: master = keypad scanner (drives), slave = calculator core.
// ----------------------------------------------------------------------------
interface keypad_scan_if;

    logic [3:0] cmd;
    logic       cmd_valid;
    logic       key_held;

    modport master (
        output cmd,
        output cmd_valid,
        output key_held
    );

    modport slave (
        input cmd,
        input cmd_valid,
        input key_held
    );

endinterface

// File: rtl/key_debounce.sv
// ----------------------------------------------------------------------------
// key_debounce
// Two-flop synchronizer for the raw keypad rows plus a stability counter that
// watches one selected row for a required level.
//   clock, reset : clock and asynchronous active-high reset
//   row_in       : raw active-low rows from the keypad pins
//   sel          : which synchronized row the counter watches
//   level        : level being qualified (0 = pressed, 1 = released)
//   count_en     : counter runs only while high, otherwise it is held at zero
//   row_sync     : synchronized rows
//   match        : selected synchronized row currently equals level
//   done         : this cycle is the DEBOUNCE_CYC-th consecutive match
// ----------------------------------------------------------------------------
module key_debounce #(
    parameter int DEBOUNCE_CYC = 20000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row_in,
    input  logic [1:0] sel,
    input  logic       level,
    input  logic       count_en,
    output logic [3:0] row_sync,
    output logic       match,
    output logic       done
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic [3:0]    row_meta_reg;
    logic [3:0]    row_sync_reg;
    logic [CW-1:0] cnt_reg;

    // Synchronizer flops clear to the idle (pulled-up) level so that a reset
    // never looks like every row being pressed at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row_meta_reg <= 4'hF;
            row_sync_reg <= 4'hF;
            cnt_reg      <= '0;
        end else begin
            row_meta_reg <= row_in;
            row_sync_reg <= row_meta_reg;
            // Any mismatching sample restarts the run of stable cycles.
            if (!count_en || !match || done) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end

    assign row_sync = row_sync_reg;
    assign match    = (row_sync_reg[sel] == level);
    assign done     = count_en && match && (cnt_reg == CW'(DEBOUNCE_CYC - 1));

endmodule

// File: rtl/keypad_scan.sv
// ----------------------------------------------------------------------------
// keypad_scan
// 4x4 matrix keypad scanner producing calculator command codes.
// Columns are driven one-cold; when a row reads low on the last dwell cycle
// of a column, the key is debounced, a single command strobe is issued, and
// the scanner waits for a debounced release before resuming the scan.
//   clock   : single clock, rising edge
//   reset   : asynchronous active-high reset
//   row_in  : keypad rows, active-low, externally pulled up
//   col_out : keypad columns, active-low, one-cold
//   kif     : command bus (cmd, cmd_valid, key_held), master side
// Parameters: SCAN_DIV (cycles per column), DEBOUNCE_CYC (stable cycles for
// press and for release).
// Optional build macro KEY_REPEAT_EN: while a key is held, re-strobe the same
// command after REPEAT_DELAY cycles from the first strobe, then every
// REPEAT_PERIOD cycles until release.
// ----------------------------------------------------------------------------
module keypad_scan
    import calc_pkg::*;
#(
    parameter int SCAN_DIV      = 1000,
    parameter int DEBOUNCE_CYC  = 20000
`ifdef KEY_REPEAT_EN
    ,
    parameter int REPEAT_DELAY  = 4 * DEBOUNCE_CYC,
    parameter int REPEAT_PERIOD = DEBOUNCE_CYC
`endif
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [3:0]   row_in,
    output logic [3:0]   col_out,
    keypad_scan_if.master kif
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    scan_state_t   state_reg;
    logic [1:0]    col_reg;
    logic [1:0]    row_lat_reg;
    logic [DW-1:0] div_reg;
    logic [3:0]    cmd_reg;
    logic          cmd_valid_reg;
    logic          key_held_reg;

    logic [3:0]    row_sync;
    logic          row_match;
    logic          stable_done;
    logic          count_en;
    logic          want_level;

`ifdef KEY_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rpt_cnt_reg;
    logic          rpt_first_reg;
    logic [RW-1:0] rpt_last;

    // Counter value on the cycle before the next strobe is due; the first
    // repeat waits the longer delay, later ones the shorter period.
    always_comb begin
        rpt_last = rpt_first_reg ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1);
    end
`endif

    // The counter qualifies a low row while debouncing a press and a high row
    // while debouncing the release; in HELD, a mismatch means "let go".
    assign count_en   = (state_reg == DEBOUNCE) || (state_reg == RELEASE);
    assign want_level = (state_reg == RELEASE);

    key_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
        .clock    (clock),
        .reset    (reset),
        .row_in   (row_in),
        .sel      (row_lat_reg),
        .level    (want_level),
        .count_en (count_en),
        .row_sync (row_sync),
        .match    (row_match),
        .done     (stable_done)
    );

    // Column decode straight from the column register, so reset forces
    // col_out to column 0 without waiting for a clock edge.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_col
            assign col_out[gi] = (col_reg != 2'(gi));
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= SCAN;
            col_reg       <= 2'd0;
            row_lat_reg   <= 2'd0;
            div_reg       <= '0;
            cmd_reg       <= 4'h0;
            cmd_valid_reg <= 1'b0;
            key_held_reg  <= 1'b0;
`ifdef KEY_REPEAT_EN
            rpt_cnt_reg   <= '0;
            rpt_first_reg <= 1'b1;
`endif
        end else begin
            cmd_valid_reg <= 1'b0;
            case (state_reg)
                SCAN: begin
                    if (div_reg == DW'(SCAN_DIV - 1)) begin
                        div_reg <= '0;
                        if (row_sync != 4'hF) begin
                            // Column stays frozen in col_reg until the key
                            // has been released.
                            row_lat_reg <= lowest_low(row_sync);
                            state_reg   <= DEBOUNCE;
                        end else begin
                            col_reg <= col_reg + 2'd1;
                        end
                    end else begin
                        div_reg <= div_reg + DW'(1);
                    end
                end

                DEBOUNCE: begin
                    if (!row_match) begin
                        // Bounce or glitch: drop it silently and move on.
                        state_reg <= SCAN;
                        col_reg   <= col_reg + 2'd1;
                    end else if (stable_done) begin
                        state_reg     <= EMIT;
                        cmd_valid_reg <= 1'b1;
                        cmd_reg       <= key_code(row_lat_reg, col_reg);
`ifdef KEY_REPEAT_EN
                        rpt_cnt_reg   <= '0;
                        rpt_first_reg <= 1'b1;
`endif
                    end
                end

                EMIT: begin
                    state_reg    <= HELD;
                    key_held_reg <= 1'b1;
`ifdef KEY_REPEAT_EN
                    rpt_cnt_reg  <= rpt_cnt_reg + RW'(1);
`endif
                end

                HELD: begin
                    if (!row_match) begin
                        state_reg    <= RELEASE;
                        key_held_reg <= 1'b0;
`ifdef KEY_REPEAT_EN
                    end else if (rpt_cnt_reg == rpt_last) begin
                        // cmd_reg still holds the original code.
                        cmd_valid_reg <= 1'b1;
                        rpt_cnt_reg   <= '0;
                        rpt_first_reg <= 1'b0;
                    end else begin
                        rpt_cnt_reg <= rpt_cnt_reg + RW'(1);
`endif
                    end
                end

                RELEASE: begin
                    if (stable_done) begin
                        state_reg <= SCAN;
                        col_reg   <= col_reg + 2'd1;
                    end
                end

                default: begin
                    state_reg <= SCAN;
                end
            endcase
        end
    end

    assign kif.cmd       = cmd_reg;
    assign kif.cmd_valid = cmd_valid_reg;
    assign kif.key_held  = key_held_reg;

endmodule

// File: tb/tb_keypad_scan.sv
// ----------------------------------------------------------------------------
// tb_keypad_scan
// Self-checking bench for keypad_scan. A keypad model shorts row r low while
// key (r,c) is pressed and column c is driven. Stimulus pushes the expected
// command of every press that must be accepted into a queue; a monitor pops
// and compares on each fresh cmd_valid strobe, and also checks that cmd holds,
// the column stays frozen while a key is held, and repeat strobe spacing when
// KEY_REPEAT_EN is defined.
// ----------------------------------------------------------------------------
module tb_keypad_scan;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 8;
`ifdef KEY_REPEAT_EN
    localparam int RDELAY   = 32;
    localparam int RPERIOD  = 8;
`endif

    typedef struct {
        logic [3:0] cmd;
        int         col;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_down [4];   // key_down[row][col]

    int   n_vec  = 0;
    int   n_miss = 0;
    exp_t exp_q [$];

    // Monitor state
    exp_t       mon_e;
    logic [3:0] last_cmd   = 4'h0;
    logic [3:0] frozen_col = 4'hF;
    logic [3:0] exp_col;
    bit         in_press   = 1'b0;
    bit         held_chk   = 1'b0;
`ifdef KEY_REPEAT_EN
    int         cyc         = 0;
    int         last_strobe = 0;
    int         n_rep       = 0;
`endif

    keypad_scan_if kif ();

    keypad_scan #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CYC (DEB)
`ifdef KEY_REPEAT_EN
        ,
        .REPEAT_DELAY (RDELAY),
        .REPEAT_PERIOD(RPERIOD)
`endif
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .row_in  (row_in),
        .col_out (col_out),
        .kif     (kif)
    );

    always #5 clock = ~clock;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_pad
            assign row_in[gi] = ~|(key_down[gi] & ~col_out);
        end
    endgenerate

    // Command code from the printed legend of each key.
    function automatic logic [3:0] code_of(input int r, input int c);
        string lay;
        byte   ch;
        lay = "123A456B789C*0#D";
        ch  = lay[r * 4 + c];
        if (ch >= "0" && ch <= "9") return 4'(ch - "0");
        case (ch)
            "A":     return 4'd10;
            "B":     return 4'd11;
            "C":     return 4'd12;
            "D":     return 4'd13;
            "#":     return 4'd14;
            default: return 4'd15;   // '*'
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic expect_key(input int r, input int c);
        exp_t e;
        e.cmd = code_of(r, c);
        e.col = c;
        exp_q.push_back(e);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_held(input string nm);
        int t;
        t = 0;
        while (!kif.key_held && t < 200) begin
            @(negedge clock);
            t++;
        end
        check(nm, 32'(kif.key_held), 32'd1);
    endtask

    // Press long enough to be accepted from any scan phase, then release.
    task automatic accept_press(input int r, input int c);
        expect_key(r, c);
        key_down[r][c] = 1'b1;
        cycles(32 + $urandom_range(0, 6));
        key_down[r][c] = 1'b0;
        cycles(4);
        check("held_cleared", 32'(kif.key_held), 32'd0);
        cycles(26);
    endtask

    // Too short to ever see DEBOUNCE_CYC consecutive low samples.
    task automatic glitch(input int r, input int c);
        key_down[r][c] = 1'b1;
        cycles($urandom_range(1, 5));
        key_down[r][c] = 1'b0;
        cycles(30);
    endtask

    // ---------------------------------------------------------------- monitor
    always @(negedge clock) begin
`ifdef KEY_REPEAT_EN
        cyc++;
`endif
        if (reset) begin
            in_press = 1'b0;
            held_chk = 1'b0;
            last_cmd = 4'h0;
        end else begin
            if (held_chk) begin
                check("held_after_emit", 32'(kif.key_held), 32'd1);
                held_chk = 1'b0;
            end
            if (kif.key_held && in_press) begin
                check("col_frozen", 32'(col_out), 32'(frozen_col));
            end
            if (!kif.cmd_valid) begin
                check("cmd_hold", 32'(kif.cmd), 32'(last_cmd));
            end else if (!kif.key_held) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_strobe: got cmd %0h, expected no strobe", kif.cmd);
                end else begin
                    mon_e   = exp_q.pop_front();
                    exp_col = ~(4'b0001 << mon_e.col);
                    check("cmd", 32'(kif.cmd), 32'(mon_e.cmd));
                    check("col_at_emit", 32'(col_out), 32'(exp_col));
                    $display("strobe cmd=%0h col_out=%b", kif.cmd, col_out);
                end
                in_press   = 1'b1;
                held_chk   = 1'b1;
                last_cmd   = kif.cmd;
                frozen_col = col_out;
`ifdef KEY_REPEAT_EN
                last_strobe = cyc;
                n_rep       = 0;
`endif
            end else begin
`ifdef KEY_REPEAT_EN
                check("repeat_gap", 32'(cyc - last_strobe), 32'((n_rep == 0) ? RDELAY : RPERIOD));
                check("repeat_cmd", 32'(kif.cmd), 32'(last_cmd));
                $display("repeat cmd=%0h gap=%0d", kif.cmd, cyc - last_strobe);
                n_rep++;
                last_strobe = cyc;
`else
                n_vec++;
                n_miss++;
                $display("FAIL repeat_strobe: got strobe while held, expected none");
`endif
            end
        end
    end

    // -------------------------------------------------------------- stimulus
    int order [16];
    int sj;
    int st;
    int t;

    initial begin
        for (int r = 0; r < 4; r++) key_down[r] = 4'h0;
        reset = 1'b1;
        cycles(2);
        check("rst_col_out",   32'(col_out),       32'hE);
        check("rst_cmd",       32'(kif.cmd),       32'h0);
        check("rst_cmd_valid", 32'(kif.cmd_valid), 32'h0);
        check("rst_key_held",  32'(kif.key_held),  32'h0);
        reset = 1'b0;
        cycles(3);

        // '6' held 100 cycles: one strobe, column 2 frozen, key_held until release
        expect_key(1, 2);
        key_down[1][2] = 1'b1;
        cycles(40);
        check("six_held", 32'(kif.key_held), 32'd1);
        check("six_col",  32'(col_out),      32'hB);
        cycles(60);
        key_down[1][2] = 1'b0;
        cycles(4);
        check("six_released", 32'(kif.key_held), 32'd0);
        cycles(26);

        // '1' bouncing every 3 cycles, then held; release bounces once
        expect_key(0, 0);
        for (int i = 0; i < 8; i++) begin
            key_down[0][0] = ~key_down[0][0];
            cycles(3);
        end
        key_down[0][0] = 1'b1;
        cycles(34);
        key_down[0][0] = 1'b0;
        cycles(4);
        key_down[0][0] = 1'b1;
        cycles(2);
        key_down[0][0] = 1'b0;
        cycles(30);
        check("one_released", 32'(kif.key_held), 32'd0);

        // 'C' for 5 cycles during column 3: rejected, scan resumes at column 0
        t = 0;
        while (col_out != 4'h7 && t < 100) begin
            @(negedge clock);
            t++;
        end
        check("wait_col3", 32'(col_out), 32'h7);
        key_down[2][3] = 1'b1;
        cycles(5);
        key_down[2][3] = 1'b0;
        t = 0;
        while (col_out == 4'h7 && t < 20) begin
            @(negedge clock);
            t++;
        end
        check("col_after_glitch", 32'(col_out), 32'hE);
        cycles(20);

        // '#' then 'B'
        accept_press(3, 2);
        accept_press(1, 3);

        // '7' accepted, other keys pressed while it is held are ignored
        expect_key(2, 0);
        key_down[2][0] = 1'b1;
        cycles(40);
        key_down[0][1] = 1'b1;
        key_down[2][1] = 1'b1;
        key_down[3][0] = 1'b1;
        cycles(10);
        key_down[0][1] = 1'b0;
        key_down[2][1] = 1'b0;
        key_down[3][0] = 1'b0;
        cycles(5);
        key_down[2][0] = 1'b0;
        cycles(30);

        // Reset while '9' is held; the still-held key is then a new press
        expect_key(2, 2);
        key_down[2][2] = 1'b1;
        wait_held("nine_held");
        #2;
        reset = 1'b1;
        #1;
        check("midrst_cmd",       32'(kif.cmd),       32'h0);
        check("midrst_cmd_valid", 32'(kif.cmd_valid), 32'h0);
        check("midrst_key_held",  32'(kif.key_held),  32'h0);
        check("midrst_col_out",   32'(col_out),       32'hE);
        cycles(3);
        expect_key(2, 2);
        reset = 1'b0;
        cycles(40);
        check("nine_repress_held", 32'(kif.key_held), 32'd1);
        key_down[2][2] = 1'b0;
        cycles(30);

`ifdef KEY_REPEAT_EN
        // 'A' held 60 cycles past the first strobe: four repeats
        expect_key(0, 3);
        key_down[0][3] = 1'b1;
        wait_held("a_held");
        cycles(59);
        key_down[0][3] = 1'b0;
        cycles(6);
        check("repeat_count", 32'(n_rep), 32'd4);
        cycles(24);
`endif

        // Every key once in random order, with random glitches interleaved
        for (int i = 0; i < 16; i++) order[i] = i;
        for (int i = 15; i > 0; i--) begin
            sj        = int'($urandom_range(0, i));
            st        = order[i];
            order[i]  = order[sj];
            order[sj] = st;
        end
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                glitch(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            end
            accept_press(order[i] / 4, order[i] % 4);
        end

        cycles(20);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000: clock cycles each column is driven.
REQ-002 SHALL have parameter DEBOUNCE_CYC, default 20000: cycles a press or release must stay stable.
REQ-003 SHALL have port clock, input, 1: the single clock; all state SHALL be clocked on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port row_in, input, 4: keypad rows, active-low, externally pulled up.
REQ-006 SHALL have port col_out, output, 4: keypad columns, active-low, one-cold.
REQ-007 SHALL have port cmd, output, 4: calculator command code, fed to the calculator core's cmd input.
REQ-008 SHALL have port cmd_valid, output, 1: one-cycle strobe marking a new cmd.
REQ-009 SHALL have port key_held, output, 1: high while an accepted key remains pressed.

Function
REQ-010 SHALL pass row_in through a 2-flop synchronizer; all logic below SHALL use only the synchronized rows.
REQ-011 SHALL use FSM states SCAN, DEBOUNCE, EMIT, HELD and RELEASE.
REQ-012 In SCAN, SHALL drive exactly one col_out bit low and advance the column index 0->1->2->3->0 every SCAN_DIV cycles.
REQ-013 In SCAN, on the last dwell cycle of a column, if any synchronized row is low, SHALL latch the column and the lowest-index low row, freeze the column, and enter DEBOUNCE.
REQ-014 DEBOUNCE SHALL count cycles with the latched row low; if that row goes high first, SHALL return to SCAN at the next column with no output.
REQ-015 When the count reaches DEBOUNCE_CYC, SHALL enter EMIT.
REQ-016 EMIT SHALL last 1 cycle: cmd_valid=1 and cmd=KEY_MAP[row*4+col]; next state is HELD.
REQ-017 cmd SHALL hold its last value between strobes.
REQ-018 HELD SHALL assert key_held until the latched row goes high, then SHALL enter RELEASE.
REQ-019 RELEASE SHALL require DEBOUNCE_CYC consecutive high cycles; a low sample SHALL restart the count.
REQ-020 When the RELEASE count completes, SHALL return to SCAN at the next column.
REQ-021 Other keys pressed while a key is in DEBOUNCE, EMIT, HELD or RELEASE SHALL be ignored.
REQ-022 Exactly one cmd_valid SHALL occur per accepted press.
REQ-023 Layout and codes: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D.
REQ-024 Digits SHALL map to their value; A=1010 (add), B=1011 (sub), C=1100 (mul), D=1101, #=1110 (equals), *=1111 (clear).

Reset
REQ-025 While reset is high: state=SCAN, column=0, col_out=4'b1110, cmd=4'h0, cmd_valid=0, key_held=0, all counters and synchronizers cleared; this SHALL take effect immediately, including mid-press.
REQ-026 After reset deasserts, a key still held SHALL be treated as a new press.

Configuration
REQ-027 With KEY_REPEAT_EN defined, HELD SHALL re-strobe cmd_valid with the same cmd after REPEAT_DELAY cycles (default 4*DEBOUNCE_CYC), then every REPEAT_PERIOD cycles (default DEBOUNCE_CYC) until release.
REQ-028 Without KEY_REPEAT_EN, the repeat counters and the REPEAT_DELAY/REPEAT_PERIOD parameters SHALL be absent, and HELD SHALL never strobe.

Structure
REQ-029 The FSM state enum, the 16-entry KEY_MAP constant and the operator command codes SHALL live in shared package calc_pkg, so the calculator core uses the same codes.
REQ-030 The synchronizer plus stability counter SHALL be a sub-module, key_debounce, instantiated once.

Verification (SCAN_DIV=4, DEBOUNCE_CYC=8, REPEAT_DELAY=32, REPEAT_PERIOD=8)
REQ-031 Hold row1 low whenever col2 is low, for 100 cycles -> exactly one cmd_valid, cmd=4'd6; key_held high until release; col_out frozen at 4'b1011 during the press.
REQ-032 Toggle row0 every 3 cycles for 24 cycles during col0, then hold it low -> exactly one strobe, cmd=4'd1.
REQ-033 Row2 low for 5 cycles only during col3 -> no strobe; scanning resumes with col_out=4'b1110 next.
REQ-034 Press '#' (row3/col2), release, then press 'B' (row1/col3) -> cmd=4'b1110, then cmd=4'b1011, two strobes total.
REQ-035 Assert reset while in HELD with cmd=4'd9 -> same cycle: cmd=0, cmd_valid=0, key_held=0, col_out=4'b1110.
REQ-036 With KEY_REPEAT_EN, hold 'A' for 60 cycles after EMIT -> strobes at EMIT, EMIT+32, EMIT+40, EMIT+48 and EMIT+56, all cmd=4'b1010.
